// File: rtl/simple_mem_be_pkg.sv
// Shared definitions for the byte-enabled RAM with clear engine:
// read-during-write mode selectors and the clear FSM state encoding.
package simple_mem_be_pkg;

    localparam int unsigned RDW_READ_FIRST  = 0;
    localparam int unsigned RDW_WRITE_FIRST = 1;

    typedef enum logic [0:0] {
        StIdle,
        StClear
    } clr_state_e;

endpackage

// File: rtl/simple_mem_be_if.sv
// Access-port bundle of simple_mem_be: request, write data, read response and clear control.
interface simple_mem_be_if #(
    parameter int unsigned WORDS = 256,
    parameter int unsigned WIDTH = 32
);
    localparam int unsigned AW = $clog2(WORDS);
    localparam int unsigned NB = WIDTH / 8;

    logic             clear;
    logic             ready;
    logic             ren;
    logic [NB-1:0]    wen;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rdata;
    logic             rvalid;

    modport master (
        output clear, ren, wen, addr, wdata,
        input  ready, rdata, rvalid
    );

    modport slave (
        input  clear, ren, wen, addr, wdata,
        output ready, rdata, rvalid
    );

endinterface

// File: rtl/simple_mem_be_array.sv
// Plain single-port synchronous RAM: byte-enabled write, registered read-first output.
// No reset on the array or its read register so the storage maps onto block RAM.
module simple_mem_be_array #(
    parameter int unsigned WORDS = 256,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     re,
    input  logic [WIDTH/8-1:0]       be,
    input  logic [$clog2(WORDS)-1:0] addr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);
    localparam int unsigned NB = WIDTH / 8;

    logic [WIDTH-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[addr];
        end
        for (int b = 0; b < NB; b++) begin
            if (be[b]) begin
                mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/simple_mem_be.sv
// Single-port RAM with byte write enables, selectable read-during-write behaviour and a
// clear engine that refills every word with INITIAL_FILL after reset or on request.
module simple_mem_be
    import simple_mem_be_pkg::*;
#(
    parameter int unsigned      WORDS        = 256,
    parameter int unsigned      WIDTH        = 32,
    parameter int unsigned      RDW_MODE     = RDW_READ_FIRST,
    parameter int unsigned      CLEAR_ON_RST = 1,
    parameter logic [WIDTH-1:0] INITIAL_FILL = '0
) (
    input logic             clk,
    input logic             rst_n,
    simple_mem_be_if.slave  bus
);
    localparam int unsigned AW = $clog2(WORDS);
    localparam int unsigned NB = WIDTH / 8;
    localparam clr_state_e  ResetState = (CLEAR_ON_RST != 0) ? StClear : StIdle;
    localparam logic [AW-1:0] LastAddr = AW'(WORDS - 1);

    clr_state_e       state_q, state_d;
    logic [AW-1:0]    clr_cnt_q, clr_cnt_d;
    logic             clearing;
    logic             accept;
    logic             rd_accept;

    logic [NB-1:0]    arr_be;
    logic [AW-1:0]    arr_addr;
    logic [WIDTH-1:0] arr_wdata;
    logic [WIDTH-1:0] arr_rdata;

    logic             rvalid_q;
    logic             rd_seen_q;
    logic [NB-1:0]    byp_be_q;
    logic [WIDTH-1:0] byp_data_q;
    logic [WIDTH-1:0] rd_word;

    assign clearing  = (state_q == StClear);
    assign bus.ready = ~clearing;
    assign accept    = bus.ready & (bus.ren | (|bus.wen));
    assign rd_accept = accept & bus.ren;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (bus.clear) begin
                    state_d = StClear;
                end
            end
            StClear: begin
                clr_cnt_d = clr_cnt_q + AW'(1);
                if (clr_cnt_q == LastAddr) begin
                    state_d   = StIdle;
                    clr_cnt_d = '0;
                end
            end
            default: begin
                state_d   = StIdle;
                clr_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ResetState;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Clear engine owns the array while clearing; user requests are already gated by ready.
    always_comb begin
        arr_be    = '0;
        arr_addr  = bus.addr;
        arr_wdata = bus.wdata;
        if (clearing) begin
            arr_be    = '1;
            arr_addr  = clr_cnt_q;
            arr_wdata = INITIAL_FILL;
        end else if (accept) begin
            arr_be    = bus.wen;
        end
    end

    simple_mem_be_array #(
        .WORDS (WORDS),
        .WIDTH (WIDTH)
    ) u_array (
        .clk   (clk),
        .re    (rd_accept),
        .be    (arr_be),
        .addr  (arr_addr),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

    // The array returns the pre-write word; write-first mode overlays the bytes written in the
    // same cycle as the read, captured alongside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q   <= 1'b0;
            rd_seen_q  <= 1'b0;
            byp_be_q   <= '0;
            byp_data_q <= '0;
        end else begin
            rvalid_q <= rd_accept;
            if (rd_accept) begin
                rd_seen_q  <= 1'b1;
                byp_be_q   <= (RDW_MODE == RDW_WRITE_FIRST) ? bus.wen : '0;
                byp_data_q <= bus.wdata;
            end
        end
    end

    always_comb begin
        rd_word = arr_rdata;
        for (int b = 0; b < NB; b++) begin
            if (byp_be_q[b]) begin
                rd_word[8*b +: 8] = byp_data_q[8*b +: 8];
            end
        end
    end

    assign bus.rdata  = rd_seen_q ? rd_word : '0;
    assign bus.rvalid = rvalid_q;

endmodule

// File: tb/tb_simple_mem_be.sv
// Scoreboard bench: a read-first and a write-first instance share the same stimulus; expected
// read responses are queued per instance and checked by a monitor on rvalid.
module tb_simple_mem_be;

    localparam int unsigned WORDS = 16;
    localparam int unsigned WIDTH = 32;
    localparam logic [31:0] FILL  = 32'hDEADBEEF;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   chk_cnt = 0;
    int   pass_cnt = 0;
    exp_t q0[$];
    exp_t q1[$];

    simple_mem_be_if #(.WORDS(WORDS), .WIDTH(WIDTH)) bus0 ();
    simple_mem_be_if #(.WORDS(WORDS), .WIDTH(WIDTH)) bus1 ();

    simple_mem_be #(
        .WORDS(WORDS), .WIDTH(WIDTH), .RDW_MODE(0), .CLEAR_ON_RST(1), .INITIAL_FILL(FILL)
    ) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    simple_mem_be #(
        .WORDS(WORDS), .WIDTH(WIDTH), .RDW_MODE(1), .CLEAR_ON_RST(1), .INITIAL_FILL(FILL)
    ) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic flag(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic ren, input logic [3:0] wen, input logic [3:0] addr,
                         input logic [31:0] wdata, input logic clear);
        bus0.ren = ren; bus0.wen = wen; bus0.addr = addr; bus0.wdata = wdata; bus0.clear = clear;
        bus1.ren = ren; bus1.wen = wen; bus1.addr = addr; bus1.wdata = wdata; bus1.clear = clear;
    endtask

    task automatic push(input logic [31:0] e0, input logic [31:0] e1);
        q0.push_back('{data: e0, due: cyc + 1});
        q1.push_back('{data: e1, due: cyc + 1});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until ready rises, bounded so a stuck clear cannot hang the run.
    task automatic wait_ready(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            n++;
            if (bus0.ready) break;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus0.rvalid) begin
            if (q0.size() == 0) flag("rvalid0_unexpected", 32'(cyc), 32'hFFFFFFFF);
            else begin
                e = q0.pop_front();
                check("rd0_latency", 32'(cyc), 32'(e.due));
                check("rd0_data", bus0.rdata, e.data);
            end
        end else if (q0.size() != 0 && q0[0].due <= cyc) begin
            e = q0.pop_front();
            flag("rvalid0_missing", 32'(cyc), 32'(e.due));
        end
        if (bus1.rvalid) begin
            if (q1.size() == 0) flag("rvalid1_unexpected", 32'(cyc), 32'hFFFFFFFF);
            else begin
                e = q1.pop_front();
                check("rd1_latency", 32'(cyc), 32'(e.due));
                check("rd1_data", bus1.rdata, e.data);
            end
        end else if (q1.size() != 0 && q1[0].due <= cyc) begin
            e = q1.pop_front();
            flag("rvalid1_missing", 32'(cyc), 32'(e.due));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready0", {31'b0, bus0.ready}, 32'd0);
        check("reset_ready1", {31'b0, bus1.ready}, 32'd0);
        check("reset_rvalid0", {31'b0, bus0.rvalid}, 32'd0);
        check("reset_rdata0", bus0.rdata, 32'd0);
        check("reset_rdata1", bus1.rdata, 32'd0);

        // Power-up clear
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready(n);
        check("rst_clear_cycles", 32'(n), 32'd16);
        check("rst_ready1", {31'b0, bus1.ready}, 32'd1);

        // Streaming reads across the whole array
        for (int a = 0; a < 16; a++) begin
            drive(1'b1, 4'h0, 4'(a), 32'h0, 1'b0);
            push(FILL, FILL);
            tick();
        end
        drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b0);
        tick();

        // Byte-enabled write over the fill pattern
        drive(1'b0, 4'b0101, 4'd5, 32'h11223344, 1'b0);
        tick();
        drive(1'b1, 4'h0, 4'd5, 32'h0, 1'b0);
        push(32'hDE22BE44, 32'hDE22BE44);
        tick();
        drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b0);
        tick();
        tick();
        check("rdata_hold", bus0.rdata, 32'hDE22BE44);
        check("rvalid_idle", {31'b0, bus0.rvalid}, 32'd0);

        // Read during write, full and partial enables
        drive(1'b0, 4'hF, 4'd3, 32'h0, 1'b0);
        tick();
        drive(1'b1, 4'hF, 4'd3, 32'hCAFEF00D, 1'b0);
        push(32'h0, 32'hCAFEF00D);
        tick();
        drive(1'b1, 4'h0, 4'd3, 32'h0, 1'b0);
        push(32'hCAFEF00D, 32'hCAFEF00D);
        tick();
        drive(1'b1, 4'b0011, 4'd4, 32'h01234567, 1'b0);
        push(32'hDEADBEEF, 32'hDEAD4567);
        tick();
        drive(1'b1, 4'h0, 4'd4, 32'h0, 1'b0);
        push(32'hDEAD4567, 32'hDEAD4567);
        tick();
        drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b0);
        tick();

        // Clear on request; requests and repeated clear pulses during clear are dropped
        drive(1'b0, 4'hF, 4'd7, 32'h12345678, 1'b0);
        tick();
        drive(1'b1, 4'h0, 4'd7, 32'h0, 1'b1);
        push(32'h12345678, 32'h12345678);
        tick();
        n = 1;
        check("clear_ready_low", {31'b0, bus0.ready}, 32'd0);
        drive(1'b1, 4'hF, 4'd7, 32'hAAAAAAAA, 1'b1);
        repeat (3) begin
            tick();
            n++;
        end
        drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b0);
        for (int i = 0; i < 40 && !bus0.ready; i++) begin
            tick();
            n++;
        end
        check("clear_cycles", 32'(n), 32'd17);
        drive(1'b1, 4'h0, 4'd7, 32'h0, 1'b0);
        push(FILL, FILL);
        tick();
        drive(1'b1, 4'h0, 4'd5, 32'h0, 1'b0);
        push(FILL, FILL);
        tick();
        drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b0);
        tick();

        // Reset right after an accepted read drops its rvalid
        drive(1'b1, 4'h0, 4'd2, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midread_rvalid0", {31'b0, bus0.rvalid}, 32'd0);
        check("midread_rvalid1", {31'b0, bus1.rvalid}, 32'd0);
        check("midread_ready", {31'b0, bus0.ready}, 32'd0);
        check("midread_rdata", bus0.rdata, 32'd0);
        drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset with the clear counter at 9 restarts a full clear
        repeat (9) tick();
        rst_n = 1'b0;
        #1;
        check("midclear_ready", {31'b0, bus0.ready}, 32'd0);
        check("midclear_rvalid", {31'b0, bus0.rvalid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready(n);
        check("restart_clear_cycles", 32'(n), 32'd16);

        for (int a = 0; a < 16; a++) begin
            drive(1'b1, 4'h0, 4'(a), 32'h0, 1'b0);
            push(FILL, FILL);
            tick();
        end
        drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b0);
        repeat (3) tick();

        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
